lap_stopwatch: RTL and testbench
================================

# lap_stopwatch

- Parametrised BCD stopwatch/timer counting MM:SS from 00:00 to 59:59.
- Successor to the single-digit-pair seconds stopwatch; adds minutes, an internal tick prescaler, up/down (countdown) mode with preset load, selectable wrap/saturate at full scale, and an optional lap-capture register.
- Sits behind the button-conditioning logic and drives the seven-segment display mux directly.

## Interface
- `TICK_DIV`, default 1: clock cycles per count tick, ≥1. Use 1 for simulation and the board clock rate for hardware.
- `WRAP`, default 1: up-mode behaviour at 59:59. 1 = wrap to 00:00. 0 = saturate and stop.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_stop` in 1: rising edge toggles run/stop.
- `clear` in 1: rising edge zeroes the time.
- `load` in 1: rising edge loads `load_val`; honoured only while stopped.
- `load_val` in 16: BCD preset `{min_tens, min_ones, sec_tens, sec_ones}`.
- `mode` in 1: 0 = count up, 1 = count down; latched at start.
- `lap` in 1: rising edge captures the current time (macro-dependent).
- `sec_ones` out 4 and `sec_tens` out 4: seconds, BCD 0–9 and 0–5.
- `min_ones` out 4 and `min_tens` out 4: minutes, BCD 0–9 and 0–5.
- `running` out 1: counter active.
- `overflow` out 1: sticky flag, up count passed 59:59.
- `done` out 1: one-cycle pulse when a countdown reaches 00:00.
- `lap_time` out 16: captured BCD time (macro-dependent).
- `lap_valid` out 1: one-cycle pulse on capture.

## Operation
- **Edge detection.** All control inputs are synchronous levels. Each keeps a previous-value register, reset to 0. An action fires once per 0→1 transition. Holding an input high does nothing further.
- **Priority within one cycle:** `clear` > `load` > `start_stop` > tick. `lap` is independent of the others.
- **`clear`.** Zeroes all four digits, the prescaler and `overflow`. `running` is unchanged. If already running, counting restarts from 00:00. Clear does not touch `lap_time`.
- **`load`.**
  - While stopped: writes `load_val` into the digits and zeroes the prescaler.
  - While running: ignored.
  - Non-BCD nibbles, or tens > 5, are clamped to 9 and 5 respectively.
- **`start_stop`.**
  - From stopped: sets `running` and latches `mode` into the internal direction bit.
  - From running: clears `running`.
  - Down mode with time 00:00: start is ignored.
  - Changes on `mode` while running have no effect.
- **Prescaler.** Counts 0..TICK_DIV-1 only while running. A tick fires when it equals TICK_DIV-1, then it returns to 0. Stopping freezes it; it does not reset.
- **Up tick.** BCD ripple: sec_ones 9→0 carries to sec_tens; sec_tens 5→0 carries to min_ones; and so on.
- **59:59 in up mode:**
  - WRAP=1: wrap to 00:00, set `overflow`, keep running.
  - WRAP=0: hold 59:59, set `overflow`, clear `running`.
- **Down tick.** BCD borrow ripple. The tick that reaches 00:00 pulses `done` and clears `running` on the same edge. A countdown never underflows.
- **Lap.** On a `lap` edge, `lap_time` ← current digits as they were before any simultaneous tick. `lap_valid` pulses for one cycle. A lap is accepted whether running or stopped.

## Timing
- **Reset.** While `reset_n` = 0, every output is 0, the prescaler is 0, the direction bit is 0 (up) and the edge registers are 0.
- **Control latency.** An input first sampled high at edge N takes effect at edge N. Outputs update after edge N.
- **Count latency.** With TICK_DIV=1, the first increment occurs at edge N+1 after a start at edge N. After that, one count per cycle.
- **General tick rate.** One tick every TICK_DIV cycles while running. The first tick comes TICK_DIV cycles after start from a zeroed prescaler.
- **Stop.** Stop at edge N means no count at edge N, even if a tick coincides.
- **Stop then start.** Resumes with the prescaler value it had when stopped.
- **Pulse outputs.** `done` and `lap_valid` are high for exactly one cycle.
- **Sticky flag.** `overflow` stays set until `clear` or reset.
- **Reset mid-count.** Assertion immediately zeroes everything, with no completion of a pending tick.

## Configuration
- `LAP_STOPWATCH_LAP_EN` defined:
  - Lap register and `lap_valid` are implemented as described.
- `LAP_STOPWATCH_LAP_EN` undefined:
  - The `lap` input is ignored.
  - `lap_time` is tied to 16'h0000 and `lap_valid` to 0.
  - No lap flops are synthesised.
  - The ports remain, so instantiations do not change.

## Test plan
- **Reset and basic count.** Reset, pulse `start_stop`, run 70 cycles (TICK_DIV=1), pulse `start_stop` → time 01:10, `running`=0. Then pulse `clear` → 00:00.
- **Up-mode full scale.** Load 16'h5958, mode=0, start, wait 2 ticks:
  - WRAP=1 → 00:00, `overflow`=1, `running`=1.
  - WRAP=0 → 59:59, `overflow`=1, `running`=0.
- **Countdown.** Load 16'h0003, mode=1, start, wait 3 ticks → 00:00, `done` high for one cycle on the third tick, `running`=0. A further start → ignored.
- **Prescaler.** TICK_DIV=4: start, wait 8 cycles → 00:02. Stop after 2 more cycles, restart, wait 2 cycles → 00:03.
- **Priority.** In one cycle, `clear` and `start_stop` rise together while running at 00:15 → 00:00, `running`=0. In another, `load` while running → digits unchanged.
- **Lap (macro defined).** `lap` rises while running at 00:42 → `lap_time`=16'h0042, `lap_valid` high for one cycle, count continues. With the macro undefined → `lap_time`=0, `lap_valid` never asserts.

Source files
------------

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: BCD MM:SS stopwatch/countdown with tick prescaler, preset load, wrap/saturate and optional lap capture (enable with LAP_STOPWATCH_LAP_EN)
module lap_stopwatch #(
  parameter int TICK_DIV = 1,
  parameter bit WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        mode,
  input  logic        lap,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic        running,
  output logic        overflow,
  output logic        done,
  output logic [15:0] lap_time,
  output logic        lap_valid
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [15:0] t, pre, clamped, inc, dec;
  logic [PW-1:0] presc;
  logic dir, ss_q, clr_q, ld_q;
  logic ss_e, clr_e, ld_e, ld_ok;
  assign {min_tens, min_ones, sec_tens, sec_ones} = t;
  assign ss_e = start_stop & ~ss_q;
  assign clr_e = clear & ~clr_q;
  assign ld_e = load & ~ld_q;
  assign ld_ok = ld_e & ~running;
  assign clamped = {load_val[15:12] > 4'd5 ? 4'd5 : load_val[15:12],
                    load_val[11:8]  > 4'd9 ? 4'd9 : load_val[11:8],
                    load_val[7:4]   > 4'd5 ? 4'd5 : load_val[7:4],
                    load_val[3:0]   > 4'd9 ? 4'd9 : load_val[3:0]};
  // time as it stands after clear/load; a down-mode start is refused if this is 00:00
  assign pre = clr_e ? '0 : ld_ok ? clamped : t;
  // BCD ripple increment and decrement of the current time
  always_comb begin
    inc = t;
    dec = t;
    inc[3:0] = sec_ones == 4'd9 ? 4'd0 : sec_ones + 4'd1;
    if (sec_ones == 4'd9) inc[7:4] = sec_tens == 4'd5 ? 4'd0 : sec_tens + 4'd1;
    if (t[7:0] == 8'h59) inc[11:8] = min_ones == 4'd9 ? 4'd0 : min_ones + 4'd1;
    if (t[11:0] == 12'h959) inc[15:12] = min_tens == 4'd5 ? 4'd0 : min_tens + 4'd1;
    dec[3:0] = sec_ones == 4'd0 ? 4'd9 : sec_ones - 4'd1;
    if (sec_ones == 4'd0) dec[7:4] = sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1;
    if (t[7:0] == 8'h00) dec[11:8] = min_ones == 4'd0 ? 4'd9 : min_ones - 4'd1;
    if (t[11:0] == 12'h000) dec[15:12] = min_tens == 4'd0 ? 4'd5 : min_tens - 4'd1;
  end
  // control edges, run state, prescaler and digit update with clear > load > start_stop > tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t <= '0;
      presc <= '0;
      dir <= 1'b0;
      running <= 1'b0;
      overflow <= 1'b0;
      done <= 1'b0;
      ss_q <= 1'b0;
      clr_q <= 1'b0;
      ld_q <= 1'b0;
    end else begin
      ss_q <= start_stop;
      clr_q <= clear;
      ld_q <= load;
      done <= 1'b0;
      if (clr_e) begin
        t <= '0;
        presc <= '0;
        overflow <= 1'b0;
      end else if (ld_ok) begin
        t <= clamped;
        presc <= '0;
      end else if (running && !ss_e) begin
        if (presc == PW'(TICK_DIV - 1)) begin
          presc <= '0;
          if (!dir) begin
            if (t == 16'h5959) begin
              overflow <= 1'b1;
              if (WRAP) t <= '0;
              else running <= 1'b0;
            end else t <= inc;
          end else if (t == 16'h0000) running <= 1'b0;
          else begin
            t <= dec;
            if (dec == 16'h0000) begin
              done <= 1'b1;
              running <= 1'b0;
            end
          end
        end else presc <= presc + PW'(1);
      end
      if (ss_e) begin
        if (running) running <= 1'b0;
        else if (!(mode && pre == 16'h0000)) begin
          running <= 1'b1;
          dir <= mode;
        end
      end
    end
  end
`ifdef LAP_STOPWATCH_LAP_EN
  logic lap_q;
  // capture the time as it was before any coincident tick on each lap edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_q <= 1'b0;
      lap_time <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_q <= lap;
      lap_valid <= lap & ~lap_q;
      if (lap && !lap_q) lap_time <= t;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_time = '0;
  assign lap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: scoreboard bench for two lap_stopwatch builds driven by shared stimulus
module tb_lap_stopwatch;
`ifdef LAP_STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int TD[2] = '{1, 4};
  localparam bit WR[2] = '{1'b1, 1'b0};
  typedef struct packed {
    logic [15:0] t;
    logic r, o, d;
    logic [15:0] lt;
    logic lv;
  } obs_t;
  typedef struct {
    int secs, presc, lap;
    bit run, dir, ovf, done, lv;
  } mdl_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic start_stop = 1'b0, clear = 1'b0, load = 1'b0, mode = 1'b0, lap = 1'b0;
  logic [15:0] load_val = '0;
  logic [3:0] so[2], st[2], mo[2], mt[2];
  logic run[2], ovf[2], dn[2], lv[2];
  logic [15:0] lt[2];
  bit ps, pc, pl, pp;
  mdl_t m[2];
  obs_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0;
  logic [15:0] presets[6] = '{16'h5958, 16'h0003, 16'h0001, 16'h5959, 16'h0000, 16'h0959};

  always #5 clk = ~clk;

  lap_stopwatch #(.TICK_DIV(1), .WRAP(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear), .load(load),
    .load_val(load_val), .mode(mode), .lap(lap), .sec_ones(so[0]), .sec_tens(st[0]),
    .min_ones(mo[0]), .min_tens(mt[0]), .running(run[0]), .overflow(ovf[0]), .done(dn[0]),
    .lap_time(lt[0]), .lap_valid(lv[0]));
  lap_stopwatch #(.TICK_DIV(4), .WRAP(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .clear(clear), .load(load),
    .load_val(load_val), .mode(mode), .lap(lap), .sec_ones(so[1]), .sec_tens(st[1]),
    .min_ones(mo[1]), .min_tens(mt[1]), .running(run[1]), .overflow(ovf[1]), .done(dn[1]),
    .lap_time(lt[1]), .lap_valid(lv[1]));

  function automatic logic [15:0] to_bcd(int s);
    int mm = s / 60, ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int to_secs(logic [15:0] v);
    int a = v[15:12] > 5 ? 5 : int'(v[15:12]);
    int b = v[11:8] > 9 ? 9 : int'(v[11:8]);
    int c = v[7:4] > 5 ? 5 : int'(v[7:4]);
    int d = v[3:0] > 9 ? 9 : int'(v[3:0]);
    return (a * 10 + b) * 60 + c * 10 + d;
  endfunction

  // reference behaviour in whole seconds
  function automatic mdl_t step(mdl_t s, bit se, bit ce, bit le, bit pe, logic [15:0] v, bit md, int td, bit wr);
    mdl_t n = s;
    n.done = 1'b0;
    n.lv = 1'b0;
    if (pe && LAP_EN) begin
      n.lap = s.secs;
      n.lv = 1'b1;
    end
    if (ce) begin
      n.secs = 0;
      n.presc = 0;
      n.ovf = 1'b0;
    end else if (le && !s.run) begin
      n.secs = to_secs(v);
      n.presc = 0;
    end else if (s.run && !se) begin
      if (s.presc == td - 1) begin
        n.presc = 0;
        if (!s.dir) begin
          if (s.secs == 3599) begin
            n.ovf = 1'b1;
            if (wr) n.secs = 0;
            else n.run = 1'b0;
          end else n.secs = s.secs + 1;
        end else if (s.secs == 0) n.run = 1'b0;
        else begin
          n.secs = s.secs - 1;
          if (n.secs == 0) begin
            n.done = 1'b1;
            n.run = 1'b0;
          end
        end
      end else n.presc = s.presc + 1;
    end
    if (se) begin
      if (s.run) n.run = 1'b0;
      else if (!(md && n.secs == 0)) begin
        n.run = 1'b1;
        n.dir = md;
      end
    end
    return n;
  endfunction

  function automatic obs_t exp_of(mdl_t s);
    return '{t: to_bcd(s.secs), r: s.run, o: s.ovf, d: s.done, lt: to_bcd(s.lap), lv: s.lv};
  endfunction

  function automatic logic [15:0] tm(int i);
    return {mt[i], mo[i], st[i], so[i]};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, expv, $time);
    end
  endtask

  task automatic cyc(input bit s = 0, input bit c = 0, input bit l = 0, input bit p = 0);
    start_stop = s;
    clear = c;
    load = l;
    lap = p;
    for (int i = 0; i < 2; i++)
      m[i] = step(m[i], s && !ps, c && !pc, l && !pl, p && !pp, load_val, mode, TD[i], WR[i]);
    q0.push_back(exp_of(m[0]));
    q1.push_back(exp_of(m[1]));
    ps = s;
    pc = c;
    pl = l;
    pp = p;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    start_stop = 0;
    clear = 0;
    load = 0;
    lap = 0;
    reset_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d time", i), tm(i), 16'h0000);
      chk($sformatf("rst%0d running", i), 16'(run[i]), 16'h0);
      chk($sformatf("rst%0d overflow", i), 16'(ovf[i]), 16'h0);
      chk($sformatf("rst%0d done", i), 16'(dn[i]), 16'h0);
      chk($sformatf("rst%0d lap_time", i), lt[i], 16'h0000);
      chk($sformatf("rst%0d lap_valid", i), 16'(lv[i]), 16'h0);
      m[i] = '{default: 0};
    end
    {ps, pc, pl, pp} = '0;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic cmp(input int i, input obs_t e);
    obs_t a;
    a = '{t: tm(i), r: run[i], o: ovf[i], d: dn[i], lt: lt[i], lv: lv[i]};
    chk($sformatf("dut%0d time", i), a.t, e.t);
    chk($sformatf("dut%0d running", i), 16'(a.r), 16'(e.r));
    chk($sformatf("dut%0d overflow", i), 16'(a.o), 16'(e.o));
    chk($sformatf("dut%0d done", i), 16'(a.d), 16'(e.d));
    chk($sformatf("dut%0d lap_time", i), a.lt, e.lt);
    chk($sformatf("dut%0d lap_valid", i), 16'(a.lv), 16'(e.lv));
  endtask

  // monitor: one expected observation per clock edge for each instance
  always begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) cmp(0, q0.pop_front());
    if (q1.size() > 0) cmp(1, q1.pop_front());
  end

  initial begin
    @(posedge clk);
    #2;
    do_reset;
    cyc(.s(1));
    repeat (70) cyc();
    cyc(.s(1));
    chk("count 70 time", tm(0), 16'h0110);
    chk("count 70 running", 16'(run[0]), 16'h0);
    chk("div4 70 time", tm(1), 16'h0017);
    cyc();
    cyc(.c(1));
    chk("clear time", tm(0), 16'h0000);
    cyc();
    load_val = 16'h5958;
    mode = 0;
    cyc(.l(1));
    cyc();
    cyc(.s(1));
    cyc();
    cyc();
    chk("wrap time", tm(0), 16'h0000);
    chk("wrap overflow", 16'(ovf[0]), 16'h1);
    chk("wrap running", 16'(run[0]), 16'h1);
    repeat (6) cyc();
    chk("sat time", tm(1), 16'h5959);
    chk("sat overflow", 16'(ovf[1]), 16'h1);
    chk("sat running", 16'(run[1]), 16'h0);
    do_reset;
    load_val = 16'h0003;
    mode = 1;
    cyc(.l(1));
    cyc();
    cyc(.s(1));
    repeat (3) cyc();
    chk("down time", tm(0), 16'h0000);
    chk("down done", 16'(dn[0]), 16'h1);
    chk("down running", 16'(run[0]), 16'h0);
    cyc();
    chk("down done pulse", 16'(dn[0]), 16'h0);
    cyc(.s(1));
    chk("down restart ignored", 16'(run[0]), 16'h0);
    cyc();
    do_reset;
    mode = 0;
    cyc(.s(1));
    repeat (8) cyc();
    chk("presc 8 time", tm(1), 16'h0002);
    repeat (2) cyc();
    cyc(.s(1));
    cyc();
    cyc(.s(1));
    cyc();
    cyc();
    chk("presc resume time", tm(1), 16'h0003);
    chk("presc div1 time", tm(0), 16'h0012);
    do_reset;
    cyc(.s(1));
    repeat (15) cyc();
    chk("prio pre time", tm(0), 16'h0015);
    cyc(.s(1), .c(1));
    chk("prio clear time", tm(0), 16'h0000);
    chk("prio clear running", 16'(run[0]), 16'h0);
    cyc();
    cyc(.s(1));
    repeat (5) cyc();
    load_val = 16'h1234;
    cyc(.l(1));
    chk("load running ignored", tm(0), 16'h0006);
    cyc();
    do_reset;
    cyc(.s(1));
    repeat (42) cyc();
    cyc(.p(1));
    chk("lap time", lt[0], LAP_EN ? 16'h0042 : 16'h0000);
    chk("lap valid", 16'(lv[0]), 16'(LAP_EN));
    chk("lap count continues", tm(0), 16'h0043);
    cyc();
    chk("lap valid pulse", 16'(lv[0]), 16'h0);
    do_reset;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 399) == 0) do_reset;
      load_val = $urandom_range(0, 2) == 0 ? presets[$urandom_range(0, 5)] : 16'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      cyc(.s($urandom_range(0, 9) == 0), .c($urandom_range(0, 59) == 0),
          .l($urandom_range(0, 19) == 0), .p($urandom_range(0, 11) == 0));
    end
    do_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
